// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// ---------------------------------------------------------------------------
// PS/2 keyboard receiver. Deserialises device-to-host frames and turns
// arrow, WASD and R make codes into single-cycle move pulses for calc.
// Typematic repeats and break codes never produce a pulse, so one physical
// press gives exactly one move.
//
// Parameters
//   FILTER_LEN  ps2_clk glitch filter depth in clk cycles
//   TIMEOUT     clk cycles without a ps2_clk falling edge before a partial
//               frame is dropped
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   ps2_clk     raw keyboard clock (asynchronous)
//   ps2_data    raw keyboard data (asynchronous)
//   up/down/left/right/key_rst
//               one-cycle key pulses, at most one high per cycle
//   scan_code   last correctly received byte, held
//   scan_valid  one-cycle pulse when scan_code updates
//   frame_err   one-cycle pulse on bad start/parity/stop or timeout
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       key_rst,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int NKEYS = 9;

    // {ext, byte} for every decoded key. Entries come in pairs (arrow, WASD)
    // that share an output, so entry gi drives output group gi/2.
    localparam logic [NKEYS*9-1:0] KEY_TABLE = {
        9'h02D,             // 8: R        -> key_rst
        9'h023, 9'h174,     // 7,6: D / E0 74 -> right
        9'h01C, 9'h16B,     // 5,4: A / E0 6B -> left
        9'h01B, 9'h172,     // 3,2: S / E0 72 -> down
        9'h01D, 9'h175      // 1,0: W / E0 75 -> up
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ---------------------------------------------------------------
    // Synchronisers and ps2_clk glitch filter
    // ---------------------------------------------------------------
    logic [1:0]            clk_sync_reg;
    logic [1:0]            data_sync_reg;
    logic [FILTER_LEN-1:0] clk_hist_reg;
    logic                  clk_filt_reg;
    logic                  clk_fall;
    logic                  din;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            clk_hist_reg  <= '1;
            clk_filt_reg  <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            clk_hist_reg  <= {clk_hist_reg[FILTER_LEN-2:0], clk_sync_reg[1]};
            if (&clk_hist_reg) begin
                clk_filt_reg <= 1'b1;
            end else if (~|clk_hist_reg) begin
                clk_filt_reg <= 1'b0;
            end
        end
    end

    // The falling edge is recognised in the cycle the history window becomes
    // all zeros while the filtered clock is still high.
    assign clk_fall = clk_filt_reg & ~|clk_hist_reg;
    assign din      = data_sync_reg[1];

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic            parity_reg, parity_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            byte_ok_next;
    logic            ferr_next;
    logic            scan_valid_reg;
    logic            frame_err_reg;
    logic [7:0]      scan_code_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            parity_reg     <= 1'b0;
            to_cnt_reg     <= '0;
            scan_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            scan_code_reg  <= 8'h00;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            parity_reg     <= parity_next;
            to_cnt_reg     <= to_cnt_next;
            scan_valid_reg <= byte_ok_next;
            frame_err_reg  <= ferr_next;
            if (byte_ok_next) begin
                scan_code_reg <= shift_reg;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        to_cnt_next  = '0;
        byte_ok_next = 1'b0;
        ferr_next    = 1'b0;

        // Timeout only runs while a frame is in progress.
        if (!clk_fall && state_reg != IDLE) begin
            to_cnt_next = to_cnt_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (clk_fall) begin
                    if (!din) begin
                        state_next   = DATA;
                        bit_cnt_next = 3'd0;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end
            end
            DATA: begin
                if (clk_fall) begin
                    shift_next   = {din, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (clk_fall) begin
                    parity_next = din;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (clk_fall) begin
                    if (din && ((^shift_reg) ^ parity_reg)) begin
                        byte_ok_next = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_reg != IDLE && !clk_fall && to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
            state_next  = IDLE;
            ferr_next   = 1'b1;
            to_cnt_next = '0;
        end
    end

    // ---------------------------------------------------------------
    // Key decode, one cycle behind scan_valid
    // ---------------------------------------------------------------
    logic             ext_reg, ext_next;
    logic             brk_reg, brk_next;
    logic [NKEYS-1:0] held_reg, held_next;
    logic [NKEYS-1:0] key_match;
    logic [NKEYS-1:0] fire;
    logic             up_reg, down_reg, left_reg, right_reg, key_rst_reg;

    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_match
            assign key_match[gi] = ({ext_reg, scan_code_reg} == KEY_TABLE[gi*9 +: 9]);
        end
    endgenerate

    always_comb begin
        ext_next  = ext_reg;
        brk_next  = brk_reg;
        held_next = held_reg;
        fire      = '0;

        if (frame_err_reg) begin
            // A damaged frame invalidates any pending prefix.
            ext_next = 1'b0;
            brk_next = 1'b0;
        end else if (scan_valid_reg) begin
            if (scan_code_reg == 8'hE0) begin
                ext_next = 1'b1;
            end else if (scan_code_reg == 8'hF0) begin
                brk_next = 1'b1;
            end else begin
                ext_next = 1'b0;
                brk_next = 1'b0;
                for (int i = 0; i < NKEYS; i++) begin
                    if (key_match[i]) begin
                        if (brk_reg) begin
                            held_next[i] = 1'b0;
                        end else if (!held_reg[i]) begin
                            fire[i]      = 1'b1;
                            held_next[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_reg     <= 1'b0;
            brk_reg     <= 1'b0;
            held_reg    <= '0;
            up_reg      <= 1'b0;
            down_reg    <= 1'b0;
            left_reg    <= 1'b0;
            right_reg   <= 1'b0;
            key_rst_reg <= 1'b0;
        end else begin
            ext_reg     <= ext_next;
            brk_reg     <= brk_next;
            held_reg    <= held_next;
            up_reg      <= fire[0] | fire[1];
            down_reg    <= fire[2] | fire[3];
            left_reg    <= fire[4] | fire[5];
            right_reg   <= fire[6] | fire[7];
            key_rst_reg <= fire[8];
        end
    end

    assign up         = up_reg;
    assign down       = down_reg;
    assign left       = left_reg;
    assign right      = right_reg;
    assign key_rst    = key_rst_reg;
    assign scan_code  = scan_code_reg;
    assign scan_valid = scan_valid_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: directed PS/2 frames, expected events queued
// by the stimulus and compared by an independent monitor.
// Bit period and timeout are scaled down from keyboard rates to keep the run short.
module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 600;
    localparam int HALF       = 100;   // half PS/2 bit period in clk cycles

    localparam logic [1:0] K_SCAN = 2'd0;
    localparam logic [1:0] K_FERR = 2'd1;
    localparam logic [1:0] K_KEY  = 2'd2;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       up, down, left, right, key_rst;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err;

    exp_t exp_q[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    int   evt_cnt   = 0;
    logic prev_sv   = 1'b0;

    ps2_key_decoder #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .key_rst   (key_rst),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [4:0] keys;
        exp_t       e;
        bit         ok;
        keys = {key_rst, right, left, down, up};
        if (scan_valid || frame_err || keys != 5'd0) begin
            check_cnt++;
            evt_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: got sv=%0b fe=%0b keys=%b code=%02h, expected no event",
                         scan_valid, frame_err, keys, scan_code);
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_SCAN:  ok = scan_valid && !frame_err && keys == 5'd0 && scan_code == e.val;
                    K_FERR:  ok = frame_err && !scan_valid && keys == 5'd0;
                    default: ok = !scan_valid && !frame_err && prev_sv &&
                                  keys == (5'd1 << e.val[2:0]);
                endcase
                if (ok) begin
                    pass_cnt++;
                    $display("evt %0d kind=%0d val=%02h ok", evt_cnt, e.kind, e.val);
                end else begin
                    $display("FAIL event_%0d: got sv=%0b fe=%0b keys=%b code=%02h prev_sv=%0b, expected kind=%0d val=%02h",
                             evt_cnt, scan_valid, frame_err, keys, scan_code, prev_sv, e.kind, e.val);
                end
            end
        end
        prev_sv = scan_valid;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        check_cnt++;
        if (act === req) begin
            pass_cnt++;
            $display("chk %s = %0h ok", name, act);
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set while clock high, then a low half-period.
    // With glitch set, a one-cycle pulse of the opposite level is inserted
    // in each half.
    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        cycles(40);
        if (glitch) begin
            ps2_clk = 1'b0;
            cycles(1);
            ps2_clk = 1'b1;
        end
        cycles(HALF - 40 - (glitch ? 1 : 0));
        ps2_clk = 1'b0;
        cycles(40);
        if (glitch) begin
            ps2_clk = 1'b1;
            cycles(1);
            ps2_clk = 1'b0;
        end
        cycles(HALF - 40 - (glitch ? 1 : 0));
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit glitch);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            send_bit(bits[i], glitch);
        end
        ps2_data = 1'b1;
        cycles(50);
    endtask

    // Clean frame; key >= 0 adds the expected key pulse after scan_valid.
    task automatic good_frame(input logic [7:0] b, input int key);
        push(K_SCAN, b);
        if (key >= 0) push(K_KEY, 8'(key));
        send_frame(b, 1'b0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int waited;
        cycles(5);
        chk("rst_scan_code", scan_code, 8'h00);
        chk("rst_outputs", {up, down, left, right, key_rst, scan_valid, frame_err}, 7'd0);
        rst = 1'b0;
        cycles(20);

        // W make -> up
        good_frame(8'h1D, 0);

        // E0 75 three times: only the first produces up
        good_frame(8'hE0, -1); good_frame(8'h75, 0);
        good_frame(8'hE0, -1); good_frame(8'h75, -1);
        good_frame(8'hE0, -1); good_frame(8'h75, -1);
        // E0 F0 75 break, then E0 75 again -> second up
        good_frame(8'hE0, -1); good_frame(8'hF0, -1); good_frame(8'h75, -1);
        good_frame(8'hE0, -1); good_frame(8'h75, 0);

        // keypad 6B is not an arrow; E0 6B is left
        good_frame(8'h6B, -1);
        good_frame(8'hE0, -1); good_frame(8'h6B, 2);

        // D with flipped parity -> frame_err only
        push(K_FERR, 8'h00);
        send_frame(8'h23, 1'b1, 1'b0);

        // partial frame then silence -> one timeout frame_err
        push(K_FERR, 8'h00);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        cycles(TIMEOUT + 300);
        // R -> key_rst
        good_frame(8'h2D, 4);

        // S with clock glitches -> exactly one down
        push(K_SCAN, 8'h1B);
        push(K_KEY, 8'd1);
        send_frame(8'h1B, 1'b0, 1'b1);

        // reset mid-frame
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        cycles(5);
        rst = 1'b1;
        cycles(3);
        chk("midrst_scan_code", scan_code, 8'h00);
        chk("midrst_outputs", {up, down, left, right, key_rst, scan_valid, frame_err}, 7'd0);
        rst = 1'b0;
        cycles(20);

        // 20 ones: each edge in IDLE with data=1 is a bad start bit
        for (int i = 0; i < 20; i++) begin
            push(K_FERR, 8'h00);
            send_bit(1'b1, 1'b0);
        end
        cycles(50);

        // held bits were cleared by reset: W pulses up again
        good_frame(8'h1D, 0);

        waited = 0;
        while (exp_q.size() != 0 && waited < 5000) begin
            cycles(1);
            waited++;
        end
        cycles(20);
        chk("pending_expected_events", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
